wb4_to_pi1: RTL and testbench

Single-clock bridge that accepts Wishbone B4 pipelined slave transactions and replays them as PI1 master operations. It is the opposite direction of pi1q_to_wb4, and lets Wishbone initiators (debug cores, DMA engines, LiteX-generated masters) reach the pi1r interconnect as one master slot. Only one transaction is outstanding at a time, with no buffering beyond that single request. Wishbone stall is used for back-pressure.

---
 rtl/pi1_pkg.sv | 21 ++
 rtl/wb4_to_pi1.sv | 110 +++++++++++
 tb/tb_wb4_to_pi1.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pi1_pkg.sv
// Shared PI1 definitions: operation codes and word-address width helpers.
package pi1_pkg;

  localparam logic [1:0] PINOOP = 2'd0;
  localparam logic [1:0] PIWROP = 2'd1;
  localparam logic [1:0] PIRDOP = 2'd2;
  localparam logic [1:0] PIRWOP = 2'd3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // A PI1 word address drops the byte-offset bits of a byte address.
  function automatic int pi1_addr_bits(input int archbitsz);
    return archbitsz - clog2(archbitsz / 8);
  endfunction

endpackage

// File: rtl/wb4_to_pi1.sv
// Wishbone B4 pipelined slave to PI1 master bridge; one transaction in flight,
// back-pressure through wb4_stall_o.
module wb4_to_pi1
  import pi1_pkg::*;
#(
  parameter int ARCHBITSZ = 32,
  localparam int ADDRBITSZ = pi1_addr_bits(ARCHBITSZ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wb4_cyc_i,
  input  logic                     wb4_stb_i,
  input  logic                     wb4_we_i,
  input  logic [ARCHBITSZ-1:0]     wb4_addr_i,
  input  logic [ARCHBITSZ-1:0]     wb4_data_i,
  input  logic [ARCHBITSZ/8-1:0]   wb4_sel_i,
  output logic                     wb4_stall_o,
  output logic                     wb4_ack_o,
  output logic [ARCHBITSZ-1:0]     wb4_data_o,
  output logic [1:0]               pi1_op_o,
  output logic [ADDRBITSZ-1:0]     pi1_addr_o,
  output logic [ARCHBITSZ-1:0]     pi1_data_o,
  input  logic [ARCHBITSZ-1:0]     pi1_data_i,
  output logic [ARCHBITSZ/8-1:0]   pi1_sel_o,
  input  logic                     pi1_rdy_i
);

  localparam int ALSB = clog2(ARCHBITSZ / 8);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAITRD = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0] state;
  logic       we_q;
  logic       ack_q;
  logic       wb_req;
  logic       unused_addr_lo;

  assign wb_req         = wb4_cyc_i & wb4_stb_i;
  assign unused_addr_lo = ^wb4_addr_i[ALSB-1:0];

  assign wb4_stall_o = (state != S_IDLE) || rst_i;
  // Gating with cyc keeps ack off the bus once the master has abandoned the cycle.
  assign wb4_ack_o   = ack_q & wb4_cyc_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      ack_q      <= 1'b0;
      wb4_data_o <= '0;
      pi1_op_o   <= PINOOP;
      pi1_addr_o <= '0;
      pi1_data_o <= '0;
      pi1_sel_o  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wb_req) begin
            we_q       <= wb4_we_i;
            pi1_addr_o <= wb4_addr_i[ARCHBITSZ-1:ALSB];
            pi1_data_o <= wb4_data_i;
            pi1_sel_o  <= wb4_sel_i;
            if (wb4_sel_i == '0) begin
              // Empty byte mask: complete locally without touching PI1.
              ack_q      <= 1'b1;
              wb4_data_o <= '0;
            end else begin
              state    <= S_ISSUE;
              pi1_op_o <= wb4_we_i ? PIWROP : PIRDOP;
            end
          end
        end
        S_ISSUE: begin
          if (pi1_rdy_i) begin
            pi1_op_o <= PINOOP;
            if (we_q) begin
              state <= S_IDLE;
              ack_q <= wb4_cyc_i;
            end else begin
              state <= wb4_cyc_i ? S_WAITRD : S_DRAIN;
            end
          end else if (!wb4_cyc_i) begin
            state    <= S_IDLE;
            pi1_op_o <= PINOOP;
          end
        end
        S_WAITRD: begin
          if (pi1_rdy_i) begin
            state <= S_IDLE;
            if (wb4_cyc_i) begin
              wb4_data_o <= pi1_data_i;
              ack_q      <= 1'b1;
            end
          end else if (!wb4_cyc_i) begin
            state <= S_DRAIN;
          end
        end
        default: begin
          // Committed read: wait it out and throw the data away.
          if (pi1_rdy_i) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb4_to_pi1.sv
// Directed bench for wb4_to_pi1 with hand-computed expectations.
module tb_wb4_to_pi1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb4_cyc_i = 1'b0;
  logic        wb4_stb_i = 1'b0;
  logic        wb4_we_i = 1'b0;
  logic [31:0] wb4_addr_i = '0;
  logic [31:0] wb4_data_i = '0;
  logic [3:0]  wb4_sel_i = '0;
  logic        wb4_stall_o;
  logic        wb4_ack_o;
  logic [31:0] wb4_data_o;
  logic [1:0]  pi1_op_o;
  logic [29:0] pi1_addr_o;
  logic [31:0] pi1_data_o;
  logic [31:0] pi1_data_i = '0;
  logic [3:0]  pi1_sel_o;
  logic        pi1_rdy_i = 1'b0;

  int checks = 0;
  int fails = 0;

  wb4_to_pi1 #(.ARCHBITSZ(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb4_cyc_i(wb4_cyc_i), .wb4_stb_i(wb4_stb_i), .wb4_we_i(wb4_we_i),
    .wb4_addr_i(wb4_addr_i), .wb4_data_i(wb4_data_i), .wb4_sel_i(wb4_sel_i),
    .wb4_stall_o(wb4_stall_o), .wb4_ack_o(wb4_ack_o), .wb4_data_o(wb4_data_o),
    .pi1_op_o(pi1_op_o), .pi1_addr_o(pi1_addr_o), .pi1_data_o(pi1_data_o),
    .pi1_data_i(pi1_data_i), .pi1_sel_o(pi1_sel_o), .pi1_rdy_i(pi1_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic request(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] sel);
    wb4_cyc_i  = 1'b1;
    wb4_stb_i  = 1'b1;
    wb4_we_i   = we;
    wb4_addr_i = addr;
    wb4_data_i = data;
    wb4_sel_i  = sel;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    checks++; if (pi1_op_o !== 2'd0) begin fails++; $display("FAIL reset_op got %0d want 0", pi1_op_o); end
    checks++; if (wb4_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", wb4_ack_o); end
    checks++; if (wb4_data_o !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", wb4_data_o); end
    checks++; if (wb4_stall_o !== 1'b1) begin fails++; $display("FAIL reset_stall_in_rst got %b want 1", wb4_stall_o); end
    rst_i = 1'b0;
    #1;
    checks++; if (wb4_stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall_after got %b want 0", wb4_stall_o); end
  endtask

  task automatic test_write();
    pi1_rdy_i = 1'b1;
    request(1'b1, 32'h1004, 32'hDEADBEEF, 4'hF);
    tick();
    wb4_stb_i = 1'b0;
    checks++; if (pi1_op_o !== 2'd1) begin fails++; $display("FAIL wr_op got %0d want 1", pi1_op_o); end
    checks++; if (pi1_addr_o !== 30'h401) begin fails++; $display("FAIL wr_addr got %h want 401", pi1_addr_o); end
    checks++; if (pi1_data_o !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_data got %h want deadbeef", pi1_data_o); end
    checks++; if (pi1_sel_o !== 4'hF) begin fails++; $display("FAIL wr_sel got %h want f", pi1_sel_o); end
    checks++; if (wb4_ack_o !== 1'b0) begin fails++; $display("FAIL wr_ack_early got %b want 0", wb4_ack_o); end
    tick();
    checks++; if (pi1_op_o !== 2'd0) begin fails++; $display("FAIL wr_op_once got %0d want 0", pi1_op_o); end
    checks++; if (wb4_ack_o !== 1'b1) begin fails++; $display("FAIL wr_ack got %b want 1", wb4_ack_o); end
    tick();
    checks++; if (wb4_ack_o !== 1'b0) begin fails++; $display("FAIL wr_ack_width got %b want 0", wb4_ack_o); end
    checks++; if (wb4_stall_o !== 1'b0) begin fails++; $display("FAIL wr_idle_stall got %b want 0", wb4_stall_o); end
  endtask

  task automatic test_read();
    pi1_rdy_i = 1'b1;
    pi1_data_i = 32'hBAD0BAD0;
    request(1'b0, 32'h2000, 32'h0, 4'hF);
    tick();
    wb4_stb_i = 1'b0;
    checks++; if (pi1_op_o !== 2'd2) begin fails++; $display("FAIL rd_op got %0d want 2", pi1_op_o); end
    checks++; if (pi1_addr_o !== 30'h800) begin fails++; $display("FAIL rd_addr got %h want 800", pi1_addr_o); end
    tick();
    pi1_rdy_i = 1'b0;
    checks++; if (pi1_op_o !== 2'd0) begin fails++; $display("FAIL rd_op_once got %0d want 0", pi1_op_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (wb4_ack_o !== 1'b0 || wb4_stall_o !== 1'b1) begin
        fails++; $display("FAIL rd_wait%0d got ack=%b stall=%b want ack=0 stall=1", i, wb4_ack_o, wb4_stall_o);
      end
    end
    pi1_rdy_i = 1'b1;
    pi1_data_i = 32'h12345678;
    tick();
    pi1_data_i = 32'hBAD0BAD0;
    checks++; if (wb4_ack_o !== 1'b1) begin fails++; $display("FAIL rd_ack got %b want 1", wb4_ack_o); end
    checks++; if (wb4_data_o !== 32'h12345678) begin fails++; $display("FAIL rd_data got %h want 12345678", wb4_data_o); end
    tick();
    checks++; if (wb4_ack_o !== 1'b0) begin fails++; $display("FAIL rd_ack_width got %b want 0", wb4_ack_o); end
  endtask

  task automatic test_back_pressure();
    pi1_rdy_i = 1'b0;
    request(1'b1, 32'h40, 32'h11111111, 4'h3);
    tick();
    request(1'b1, 32'h80, 32'h22222222, 4'hF);
    for (int i = 0; i < 10; i++) begin
      checks++; if (wb4_stall_o !== 1'b1 || pi1_op_o !== 2'd1 || pi1_addr_o !== 30'h10 || pi1_data_o !== 32'h11111111) begin
        fails++; $display("FAIL bp_hold%0d got stall=%b op=%0d addr=%h data=%h want 1 1 10 11111111",
                          i, wb4_stall_o, pi1_op_o, pi1_addr_o, pi1_data_o);
      end
      tick();
    end
    pi1_rdy_i = 1'b1;
    checks++; if (wb4_ack_o !== 1'b0) begin fails++; $display("FAIL bp_no_ack got %b want 0", wb4_ack_o); end
    tick();
    checks++; if (wb4_ack_o !== 1'b1 || wb4_stall_o !== 1'b0) begin
      fails++; $display("FAIL bp_first_ack got ack=%b stall=%b want 1 0", wb4_ack_o, wb4_stall_o);
    end
    checks++; if (pi1_addr_o !== 30'h10) begin fails++; $display("FAIL bp_not_captured got %h want 10", pi1_addr_o); end
    tick();
    wb4_stb_i = 1'b0;
    checks++; if (pi1_op_o !== 2'd1 || pi1_addr_o !== 30'h20 || pi1_data_o !== 32'h22222222 || pi1_sel_o !== 4'hF) begin
      fails++; $display("FAIL bp_second got op=%0d addr=%h data=%h sel=%h want 1 20 22222222 f",
                        pi1_op_o, pi1_addr_o, pi1_data_o, pi1_sel_o);
    end
    checks++; if (wb4_ack_o !== 1'b0) begin fails++; $display("FAIL bp_ack_width got %b want 0", wb4_ack_o); end
    tick();
    checks++; if (wb4_ack_o !== 1'b1) begin fails++; $display("FAIL bp_second_ack got %b want 1", wb4_ack_o); end
    tick();
  endtask

  task automatic test_cyc_drop_issue();
    pi1_rdy_i = 1'b0;
    request(1'b0, 32'h300, 32'h0, 4'hF);
    tick();
    checks++; if (pi1_op_o !== 2'd2) begin fails++; $display("FAIL drop_issue_op got %0d want 2", pi1_op_o); end
    wb4_cyc_i = 1'b0;
    wb4_stb_i = 1'b0;
    tick();
    checks++; if (pi1_op_o !== 2'd0 || wb4_stall_o !== 1'b0) begin
      fails++; $display("FAIL drop_issue_idle got op=%0d stall=%b want 0 0", pi1_op_o, wb4_stall_o);
    end
    wb4_cyc_i = 1'b1;
    pi1_rdy_i = 1'b1;
    tick();
    checks++; if (wb4_ack_o !== 1'b0 || pi1_op_o !== 2'd0) begin
      fails++; $display("FAIL drop_issue_no_ack got ack=%b op=%0d want 0 0", wb4_ack_o, pi1_op_o);
    end
    wb4_cyc_i = 1'b0;
  endtask

  task automatic test_cyc_drop_waitrd();
    pi1_rdy_i = 1'b1;
    request(1'b0, 32'h400, 32'h0, 4'hF);
    tick();
    wb4_stb_i = 1'b0;
    tick();
    pi1_rdy_i = 1'b0;
    wb4_cyc_i = 1'b0;
    tick();
    checks++; if (wb4_stall_o !== 1'b1) begin fails++; $display("FAIL drain_stall got %b want 1", wb4_stall_o); end
    wb4_cyc_i = 1'b1;
    tick();
    checks++; if (wb4_stall_o !== 1'b1) begin fails++; $display("FAIL drain_hold got %b want 1", wb4_stall_o); end
    pi1_rdy_i = 1'b1;
    pi1_data_i = 32'hCAFEF00D;
    tick();
    checks++; if (wb4_stall_o !== 1'b0 || wb4_ack_o !== 1'b0) begin
      fails++; $display("FAIL drain_exit got stall=%b ack=%b want 0 0", wb4_stall_o, wb4_ack_o);
    end
    checks++; if (wb4_data_o !== 32'h12345678) begin fails++; $display("FAIL drain_discard got %h want 12345678", wb4_data_o); end
    tick();
    checks++; if (wb4_ack_o !== 1'b0) begin fails++; $display("FAIL drain_no_ack got %b want 0", wb4_ack_o); end
    wb4_cyc_i = 1'b0;
  endtask

  task automatic test_sel_zero();
    pi1_rdy_i = 1'b1;
    request(1'b1, 32'h500, 32'h55555555, 4'h0);
    tick();
    wb4_stb_i = 1'b0;
    checks++; if (wb4_ack_o !== 1'b1 || pi1_op_o !== 2'd0 || wb4_stall_o !== 1'b0 || wb4_data_o !== 32'h0) begin
      fails++; $display("FAIL sel0 got ack=%b op=%0d stall=%b rdata=%h want 1 0 0 0",
                        wb4_ack_o, pi1_op_o, wb4_stall_o, wb4_data_o);
    end
    tick();
    checks++; if (wb4_ack_o !== 1'b0 || pi1_op_o !== 2'd0) begin
      fails++; $display("FAIL sel0_after got ack=%b op=%0d want 0 0", wb4_ack_o, pi1_op_o);
    end
    wb4_cyc_i = 1'b0;
  endtask

  task automatic test_reset_waitrd();
    pi1_rdy_i = 1'b1;
    pi1_data_i = 32'h0BADF00D;
    request(1'b0, 32'h600, 32'hA5A5A5A5, 4'h5);
    tick();
    wb4_stb_i = 1'b0;
    tick();
    pi1_rdy_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if (pi1_op_o !== 2'd0 || pi1_addr_o !== 30'h0 || pi1_data_o !== 32'h0 || pi1_sel_o !== 4'h0) begin
      fails++; $display("FAIL rst_wait_pi1 got op=%0d addr=%h data=%h sel=%h want all 0",
                        pi1_op_o, pi1_addr_o, pi1_data_o, pi1_sel_o);
    end
    checks++; if (wb4_ack_o !== 1'b0 || wb4_data_o !== 32'h0) begin
      fails++; $display("FAIL rst_wait_wb got ack=%b rdata=%h want 0 0", wb4_ack_o, wb4_data_o);
    end
    #1;
    checks++; if (wb4_stall_o !== 1'b0) begin fails++; $display("FAIL rst_wait_idle got stall=%b want 0", wb4_stall_o); end
    pi1_rdy_i = 1'b1;
    tick();
    checks++; if (wb4_ack_o !== 1'b0 || wb4_data_o !== 32'h0) begin
      fails++; $display("FAIL rst_wait_no_ack got ack=%b rdata=%h want 0 0", wb4_ack_o, wb4_data_o);
    end
    wb4_cyc_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_pressure();
    test_cyc_drop_issue();
    test_cyc_drop_waitrd();
    test_sel_zero();
    test_reset_waitrd();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
